// File: rtl/pipe_stage_skid_pkg.sv
// Shared encodings for the skid-buffered pipeline stage:
// bubble ctrl values and occupancy FSM states.
package pipe_stage_skid_pkg;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam logic [1:0] GPR_XP   = 2'b00;
    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [3:0] CTRL_NOP = {GPR_XP, M2R_ALU};

    function automatic logic [1:0] occ_count(occ_e s);
        return s;
    endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// 32-bit enabled wrap-around event counter, async active-low reset.
// Only built when PIPE_STAGE_PERF_EN is defined.
`ifdef PIPE_STAGE_PERF_EN
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] cnt
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`endif

// File: rtl/pipe_stage_skid.sv
// Generic pipeline register with 2-entry skid buffer and flush.
// PIPE_STAGE_PERF_EN adds stall/bubble performance counters.
module pipe_stage_skid
    import pipe_stage_skid_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                CTRL_W      = 4,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(CTRL_NOP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_bubble_cnt
`endif
);

    occ_e              state_q;
    occ_e              state_d;
    logic              main_v_q;
    logic              main_v_d;
    logic [CTRL_W-1:0] main_ctrl_q;
    logic [CTRL_W-1:0] main_ctrl_d;
    logic [DATA_W-1:0] main_data_q;
    logic [DATA_W-1:0] main_data_d;
    logic              skid_v_q;
    logic              skid_v_d;
    logic [CTRL_W-1:0] skid_ctrl_q;
    logic [CTRL_W-1:0] skid_ctrl_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [DATA_W-1:0] skid_data_d;
    logic              in_fire;
    logic              out_fire;

    // in_ready depends on the skid flop only, never on out_ready
    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_ctrl  = main_v_q ? main_ctrl_q : BUBBLE_CTRL;
    assign out_data  = main_data_q;
    assign occupancy = occ_count(state_q);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = main_v_q & out_ready;

    always_comb begin
        state_d     = state_q;
        main_v_d    = main_v_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_v_d    = skid_v_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
            state_d     = OCC_EMPTY;
            main_v_d    = 1'b0;
            main_ctrl_d = BUBBLE_CTRL;
            skid_v_d    = 1'b0;
            skid_ctrl_d = BUBBLE_CTRL;
        end else begin
            unique case (state_q)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        state_d     = OCC_ONE;
                        main_v_d    = 1'b1;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (in_fire) begin
                        state_d     = OCC_FULL;
                        skid_v_d    = 1'b1;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (out_fire) begin
                        state_d     = OCC_EMPTY;
                        main_v_d    = 1'b0;
                        main_ctrl_d = BUBBLE_CTRL;
                    end
                end
                OCC_FULL: begin
                    if (out_fire) begin
                        state_d     = OCC_ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_v_d    = 1'b0;
                        skid_ctrl_d = BUBBLE_CTRL;
                    end
                end
                default: begin
                    state_d = OCC_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= OCC_EMPTY;
            main_v_q    <= 1'b0;
            main_ctrl_q <= BUBBLE_CTRL;
            main_data_q <= '0;
            skid_v_q    <= 1'b0;
            skid_ctrl_q <= BUBBLE_CTRL;
            skid_data_q <= '0;
        end else begin
            state_q     <= state_d;
            main_v_q    <= main_v_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_v_q    <= skid_v_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_perf_cnt u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (main_v_q & ~out_ready),
        .cnt   (perf_stall_cnt)
    );

    pipe_perf_cnt u_bubble_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (~main_v_q),
        .cnt   (perf_bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed scoreboard bench for pipe_stage_skid.
// Build with PIPE_STAGE_PERF_EN to also cover the perf counters.
module tb_pipe_stage_skid;

    localparam logic [3:0] BUB = 4'hA;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ctrl;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_ctrl;
    logic [31:0] out_data;
    logic [1:0]  occupancy;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_bubble_cnt;
    logic [31:0] stall_m;
    logic [31:0] bubble_m;
`endif

    int n_vec;
    int n_err;
    logic [35:0] sb[$];

    pipe_stage_skid #(
        .DATA_W      (32),
        .CTRL_W      (4),
        .BUBBLE_CTRL (BUB)
    ) dut (
        .clk       (clk),
        .reset     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c,
                         input logic [31:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    // Scoreboard: pop on out_fire, push on in_fire, clear on flush/reset
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
`ifdef PIPE_STAGE_PERF_EN
            stall_m  = '0;
            bubble_m = '0;
`endif
        end else begin
`ifdef PIPE_STAGE_PERF_EN
            chk("perf_stall", 64'(perf_stall_cnt), 64'(stall_m));
            chk("perf_bubble", 64'(perf_bubble_cnt), 64'(bubble_m));
            if (out_valid && !out_ready) stall_m = stall_m + 32'd1;
            if (!out_valid) bubble_m = bubble_m + 32'd1;
`endif
            if (!out_valid) begin
                chk("bubble_ctrl", 64'(out_ctrl), 64'(BUB));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(1), 64'(0));
                end else begin
                    chk("sb_beat", 64'({out_ctrl, out_data}),
                        64'(sb.pop_front()));
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && in_ready) begin
                sb.push_back({in_ctrl, in_data});
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 4'h0, 32'h0);
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_occ", 64'(occupancy), 64'(0));
        chk("rst_out_ctrl", 64'(out_ctrl), 64'(BUB));
        chk("rst_out_data", 64'(out_data), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;

        // T1: async reset while FULL and stalled
        drive(1'b1, 4'h1, 32'hA1);
        tick();
        drive(1'b1, 4'h2, 32'hA2);
        tick();
        drive(1'b0, 4'h0, 32'h0);
        chk("t1_occ_full", 64'(occupancy), 64'(2));
        chk("t1_ready_full", 64'(in_ready), 64'(0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t1_out_valid", 64'(out_valid), 64'(0));
        chk("t1_occ", 64'(occupancy), 64'(0));
        chk("t1_out_ctrl", 64'(out_ctrl), 64'(BUB));
        chk("t1_out_data", 64'(out_data), 64'(0));
        chk("t1_in_ready", 64'(in_ready), 64'(1));
        tick();
        rst_n = 1'b1;
        tick();

        // T2: streaming at full rate
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            drive(1'b1, 4'(i + 3), 32'(i));
            tick();
            chk("t2_valid", 64'(out_valid), 64'(1));
            chk("t2_data", 64'(out_data), 64'(i));
            chk("t2_occ", 64'(occupancy), 64'(1));
        end
        drive(1'b0, 4'h0, 32'h0);
        tick();
        chk("t2_drain", 64'(occupancy), 64'(0));

        // T3: stall fills skid, release drains in order
        out_ready = 1'b0;
        drive(1'b1, 4'h3, 32'hA);
        tick();
        chk("t3_ready_a", 64'(in_ready), 64'(1));
        drive(1'b1, 4'h4, 32'hB);
        tick();
        chk("t3_ready_b", 64'(in_ready), 64'(0));
        chk("t3_occ_b", 64'(occupancy), 64'(2));
        drive(1'b1, 4'h5, 32'hC);
        tick();
        tick();
        chk("t3_hold_data", 64'(out_data), 64'hA);
        chk("t3_hold_occ", 64'(occupancy), 64'(2));
        out_ready = 1'b1;
        tick();
        chk("t3_rel_data", 64'(out_data), 64'hB);
        chk("t3_rel_ready", 64'(in_ready), 64'(1));
        tick();
        drive(1'b0, 4'h0, 32'h0);
        chk("t3_c_data", 64'(out_data), 64'hC);
        tick();
        chk("t3_empty", 64'(occupancy), 64'(0));

        // T4: flush while full, then flush against an accepted beat
        out_ready = 1'b0;
        drive(1'b1, 4'h6, 32'h11);
        tick();
        drive(1'b1, 4'h7, 32'h22);
        tick();
        chk("t4_full", 64'(occupancy), 64'(2));
        flush = 1'b1;
        drive(1'b1, 4'h8, 32'h33);
        tick();
        flush = 1'b0;
        drive(1'b0, 4'h0, 32'h0);
        chk("t4_valid", 64'(out_valid), 64'(0));
        chk("t4_ctrl", 64'(out_ctrl), 64'(BUB));
        chk("t4_occ", 64'(occupancy), 64'(0));
        chk("t4_ready", 64'(in_ready), 64'(1));
        drive(1'b1, 4'h9, 32'h44);
        tick();
        flush = 1'b1;
        drive(1'b1, 4'hB, 32'h55);
        tick();
        flush = 1'b0;
        drive(1'b0, 4'h0, 32'h0);
        chk("t4b_valid", 64'(out_valid), 64'(0));
        chk("t4b_data", 64'(out_data), 64'h44);
        tick();
        chk("t4b_dropped", 64'(out_valid), 64'(0));

        // T5: one-cycle bubble in a stream
        out_ready = 1'b1;
        drive(1'b1, 4'hC, 32'h61);
        tick();
        drive(1'b0, 4'h0, 32'h0);
        tick();
        chk("t5_valid", 64'(out_valid), 64'(0));
        chk("t5_ctrl", 64'(out_ctrl), 64'(BUB));
        chk("t5_data", 64'(out_data), 64'h61);
        drive(1'b1, 4'hD, 32'h62);
        tick();
        drive(1'b0, 4'h0, 32'h0);
        chk("t5_next", 64'(out_data), 64'h62);
        tick();

`ifdef PIPE_STAGE_PERF_EN
        // T6: stall counter wraps from all-ones
        out_ready = 1'b0;
        drive(1'b1, 4'hE, 32'h71);
        tick();
        drive(1'b0, 4'h0, 32'h0);
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.u_stall_cnt.cnt_q;
        stall_m = 32'hFFFF_FFFF;
        tick();
        chk("t6_wrap", 64'(perf_stall_cnt), 64'(0));
        out_ready = 1'b1;
        tick();
        tick();
`endif

        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
